// File: rtl/m_dram_dcache.sv
// Direct-mapped, write-through, one-word-line data cache in front of the stalling pseudo-DRAM.
// Misses issue one read strobe and stall the core. Sub-word stores become read-modify-write.
module m_dram_dcache #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned IDX_W   = 4,
  parameter int unsigned DRAM_AW = 11
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [31:0]       c_wdata,
  input  logic [3:0]        c_we,
  input  logic              c_re,
  output logic [31:0]       c_rdata,
  output logic              c_stall,
  output logic [ADDR_W-1:0] m_addr,
  output logic [31:0]       m_wdata,
  output logic [3:0]        m_we,
  output logic              m_oe,
  input  logic [31:0]       m_rdata,
  input  logic              m_stall
);

  localparam int unsigned TagW  = ADDR_W - IDX_W - 2;
  localparam int unsigned Lines = 1 << IDX_W;

  if (DRAM_AW + 2 > ADDR_W) begin : g_bad_dram_aw
    $error("DRAM_AW does not fit in ADDR_W");
  end

  typedef enum logic {StIdle, StWait} state_e;

  state_e            state_q;
  logic [Lines-1:0]  valid_q;
  logic [TagW-1:0]   tag_q  [Lines];
  logic [31:0]       data_q [Lines];
  logic [ADDR_W-3:0] miss_word_q;

  logic [IDX_W-1:0] idx;
  logic [TagW-1:0]  tag;
  logic             hit, store, full_store, issue;
  logic [31:0]      line_word, merged;
  logic             line_we;
  logic [IDX_W-1:0] line_idx;
  logic [TagW-1:0]  line_tag;
  logic [31:0]      line_wdata;
  logic             unused_addr_lsb;

  assign unused_addr_lsb = ^c_addr[1:0];
  assign idx        = c_addr[IDX_W+1:2];
  assign tag        = c_addr[ADDR_W-1:IDX_W+2];
  assign line_word  = data_q[idx];
  assign hit        = valid_q[idx] && (tag_q[idx] == tag);
  assign store      = |c_we;
  assign full_store = &c_we;

  // Store lanes override the cached word; with all lanes enabled this is just c_wdata.
  always_comb begin
    merged = line_word;
    for (int b = 0; b < 4; b++) begin
      if (c_we[b]) merged[8*b +: 8] = c_wdata[8*b +: 8];
    end
  end

  always_comb begin
    c_rdata    = '0;
    c_stall    = 1'b0;
    m_addr     = {c_addr[ADDR_W-1:2], 2'b00};
    m_wdata    = merged;
    m_we       = 4'h0;
    m_oe       = 1'b0;
    issue      = 1'b0;
    line_we    = 1'b0;
    line_idx   = idx;
    line_tag   = tag;
    line_wdata = merged;
    unique case (state_q)
      StIdle: begin
        if (full_store || (store && hit)) begin
          m_we    = 4'hF;
          line_we = 1'b1;
        end else if ((store || c_re) && !hit) begin
          c_stall = 1'b1;
          // A busy DRAM may still be finishing a read abandoned by reset.
          if (!m_stall) begin
            m_oe  = 1'b1;
            issue = 1'b1;
          end
        end else if (c_re) begin
          c_rdata = line_word;
        end
      end
      StWait: begin
        c_stall    = 1'b1;
        m_addr     = {miss_word_q, 2'b00};
        line_idx   = miss_word_q[IDX_W-1:0];
        line_tag   = miss_word_q[ADDR_W-3:IDX_W];
        line_wdata = m_rdata;
        line_we    = !m_stall;
      end
      default: ;
    endcase
    if (i_rst) begin
      m_oe    = 1'b0;
      m_we    = 4'h0;
      issue   = 1'b0;
      line_we = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= StIdle;
      valid_q <= '0;
    end else begin
      if (line_we) begin
        valid_q[line_idx] <= 1'b1;
        tag_q[line_idx]   <= line_tag;
        data_q[line_idx]  <= line_wdata;
      end
      unique case (state_q)
        StIdle: begin
          if (issue) begin
            state_q     <= StWait;
            miss_word_q <= c_addr[ADDR_W-1:2];
          end
        end
        StWait: begin
          if (!m_stall) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
